// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory.
// Port A has fixed priority; port B gets a starvation guard and a write-window check.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] B_WIN_LO     = 32'h0000_0000,
  parameter logic [31:0] B_WIN_HI     = 32'h0000_03FC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] wdata_a,
  output logic        ack_a,
  output logic [31:0] rdata_a,
  output logic        stall_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        ack_b,
  output logic [31:0] rdata_b,
  output logic        err_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  logic [1:0]  state_q;
  logic        owner_b_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  starve_q;
  logic [31:0] rdata_a_q;
  logic [31:0] rdata_b_q;

  logic grant_a;
  logic grant_b;
  logic in_window;
  logic reject;
  logic in_acc;
  logic in_resp;

  always_comb begin
    grant_b = req_b & (~req_a | (starve_q >= StarveLimit));
    grant_a = req_a & ~grant_b;
    // Single unsigned range check: wraps below B_WIN_LO, so it covers both bounds.
    in_window = ((addr_q - B_WIN_LO) <= (B_WIN_HI - B_WIN_LO)) & (addr_q[1:0] == 2'b00);
    reject    = owner_b_q & we_q & ~in_window;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_a | grant_b) begin
            state_q   <= StAcc;
            owner_b_q <= grant_b;
            we_q      <= grant_b ? we_b    : we_a;
            addr_q    <= grant_b ? addr_b  : addr_a;
            wdata_q   <= grant_b ? wdata_b : wdata_a;
            if (grant_b) begin
              starve_q <= '0;
            end else if (req_b && (starve_q != 8'hFF)) begin
              starve_q <= starve_q + 8'd1;
            end
          end
        end
        StAcc: begin
          if (!we_q) begin
            if (owner_b_q) rdata_b_q <= mem_rdata;
            else           rdata_a_q <= mem_rdata;
          end
          state_q <= StResp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_acc    = (state_q == StAcc);
    in_resp   = (state_q == StResp);
    mem_read  = in_acc & ~we_q;
    mem_write = in_acc & we_q & ~reject;
    mem_addr  = in_acc ? addr_q  : '0;
    mem_wdata = in_acc ? wdata_q : '0;
    ack_a     = in_resp & ~owner_b_q;
    ack_b     = in_resp & owner_b_q;
    err_b     = ack_b & reject;
    stall_a   = req_a & ~ack_a;
    busy      = (state_q != StIdle);
    rdata_a   = rdata_a_q;
    rdata_b   = rdata_b_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: a transaction-timeline model predicts every output
// each cycle; directed cases pin latency, window rejection, starvation order and reset.
module tb_dmem_arbiter;

  localparam int unsigned    LIMIT  = 4;
  localparam logic [31:0]    WIN_LO = 32'h0000_0000;
  localparam logic [31:0]    WIN_HI = 32'h0000_03FC;

  logic        clk, reset;
  logic        req_a, we_a, ack_a, stall_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, we_b, ack_b, err_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .B_WIN_LO(WIN_LO), .B_WIN_HI(WIN_HI)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a), .stall_a(stall_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b), .err_b(err_b),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [9:0] i);
    if (i == 10'd0) return 32'h0000_0018;
    return ({22'b0, i} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory attached to the DUT: untouched words read back their init pattern.
  logic [31:0] mem    [0:1023];
  bit          mem_wr [0:1023];
  assign mem_rdata = mem_wr[mem_addr[11:2]] ? mem[mem_addr[11:2]] : init_val(mem_addr[11:2]);
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[11:2]]    <= mem_wdata;
      mem_wr[mem_addr[11:2]] <= 1'b1;
    end
  end

  // Model: one transaction at a time, described by the cycle it was granted.
  logic [31:0] shadow [0:1023];
  int          cyc, m_grant_cyc, m_starve;
  bit          m_owner_b, m_we, m_rej;
  logic [31:0] m_addr, m_wdata, m_rdata_a, m_rdata_b;

  int n_cmp, n_fail;
  bit          obs_ack_a, obs_ack_b, obs_err_b, obs_busy;
  logic [31:0] obs_rdata_a;
  bit          acc_mem_read, acc_mem_write;
  logic [31:0] acc_mem_addr;

  function automatic bit b_reject(input logic [31:0] a);
    return (longint'(a) < longint'(WIN_LO)) || (longint'(a) > longint'(WIN_HI)) ||
           (a[1:0] != 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_grant_cyc = -100;
    m_starve    = 0;
    m_rdata_a   = '0;
    m_rdata_b   = '0;
  endtask

  task automatic model_update();
    int  off;
    bit  ga, gb;
    off = cyc - m_grant_cyc;
    if (reset) begin
      model_reset();
    end else if (off == 1) begin
      if (!m_we) begin
        if (m_owner_b) m_rdata_b = shadow[m_addr[11:2]];
        else           m_rdata_a = shadow[m_addr[11:2]];
      end else if (!m_rej) begin
        shadow[m_addr[11:2]] = m_wdata;
      end
    end else if (off >= 3) begin
      gb = req_b && (!req_a || m_starve >= int'(LIMIT));
      ga = req_a && !gb;
      if (ga || gb) begin
        m_grant_cyc = cyc;
        m_owner_b   = gb;
        m_we        = gb ? we_b    : we_a;
        m_addr      = gb ? addr_b  : addr_a;
        m_wdata     = gb ? wdata_b : wdata_a;
        m_rej       = gb && m_we && b_reject(m_addr);
        if (gb) m_starve = 0;
        else if (req_b && m_starve < 255) m_starve++;
      end
    end
  endtask

  // One clock cycle: compare every output against the model, then advance the model.
  task automatic step();
    int off;
    bit acc, resp;
    @(negedge clk);
    off  = cyc - m_grant_cyc;
    acc  = (off == 1);
    resp = (off == 2);
    chk("mem_read",  mem_read,  acc && !m_we);
    chk("mem_write", mem_write, acc && m_we && !m_rej);
    chk("mem_addr",  mem_addr,  acc ? m_addr  : 32'h0);
    chk("mem_wdata", mem_wdata, acc ? m_wdata : 32'h0);
    chk("ack_a",     ack_a,     resp && !m_owner_b);
    chk("ack_b",     ack_b,     resp && m_owner_b);
    chk("err_b",     err_b,     resp && m_owner_b && m_rej);
    chk("rdata_a",   rdata_a,   m_rdata_a);
    chk("rdata_b",   rdata_b,   m_rdata_b);
    chk("busy",      busy,      acc || resp);
    chk("stall_a",   stall_a,   req_a && !(resp && !m_owner_b));
    obs_ack_a   = ack_a;
    obs_ack_b   = ack_b;
    obs_err_b   = err_b;
    obs_busy    = busy;
    obs_rdata_a = rdata_a;
    if (acc) begin
      acc_mem_read  = mem_read;
      acc_mem_write = mem_write;
      acc_mem_addr  = mem_addr;
    end
    model_update();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input bit b, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
    lat = 0;
    if (b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
    else   begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
    step();
    while (!(b ? obs_ack_b : obs_ack_a) && lat < 20) begin
      lat++;
      step();
    end
    if (lat >= 20) chk("txn_timeout", 32'(lat), 32'd2);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom % 7)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0068;
      2:       return 32'h0000_03FC;
      3:       return 32'h0000_0400;
      4:       return 32'h4000_0010;
      5:       return 32'($urandom_range(0, 1023)) * 32'd4;
      default: return 32'h0000_006A;
    endcase
  endfunction

  initial begin
    int lat, k, wait_a, wait_b;
    bit pend_a, pend_b, who_b;
    n_cmp = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(10'(i));
    acc_mem_read = 0; acc_mem_write = 0; acc_mem_addr = '0;
    reset = 1'b1;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    model_reset();
    @(posedge clk); #1;
    step();
    chk("reset_busy", 32'(obs_busy), 32'd0);
    reset = 1'b0;

    // A read of word 0: access one cycle after grant, ack one cycle later.
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, lat);
    chk("a_read_latency", 32'(lat), 32'd2);
    chk("a_read_memread", 32'(acc_mem_read), 32'd1);
    chk("a_read_rdata", obs_rdata_a, 32'h0000_0018);
    step();
    chk("a_read_idle_busy", 32'(obs_busy), 32'd0);

    // A may write the digit register; no window check applies.
    run_txn(1'b0, 1'b1, 32'h4000_0010, 32'h123, lat);
    chk("a_wr_memwrite", 32'(acc_mem_write), 32'd1);
    chk("a_wr_addr", acc_mem_addr, 32'h4000_0010);
    chk("a_wr_err", 32'(obs_err_b), 32'd0);
    step();

    run_txn(1'b1, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, lat);
    chk("b_wr_out_memwrite", 32'(acc_mem_write), 32'd0);
    chk("b_wr_out_ack", 32'(obs_ack_b), 32'd1);
    chk("b_wr_out_err", 32'(obs_err_b), 32'd1);
    step();
    run_txn(1'b1, 1'b1, 32'h0000_0068, 32'hCAFE_0068, lat);
    chk("b_wr_in_memwrite", 32'(acc_mem_write), 32'd1);
    chk("b_wr_in_err", 32'(obs_err_b), 32'd0);
    step();

    // Both requesting continuously: B wins every fifth grant.
    req_a = 1; we_a = 0; addr_a = 32'h10;
    req_b = 1; we_b = 0; addr_b = 32'h20;
    for (k = 0; k < 10; k++) begin
      lat = 0;
      step();
      while (!(obs_ack_a || obs_ack_b) && lat < 20) begin lat++; step(); end
      who_b = obs_ack_b;
      chk("grant_order", 32'(who_b), 32'((k % 5) == 4));
    end
    req_a = 0; req_b = 0;
    step();

    // Reset during the access cycle of a B write aborts it.
    req_b = 1; we_b = 1; addr_b = 32'h80; wdata_b = 32'h1234_5678;
    step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_b = 0;
    step();
    reset = 1'b0;
    chk("rst_no_write", 32'(mem_wr[32]), 32'd0);
    run_txn(1'b0, 1'b0, 32'h80, 32'h0, lat);
    chk("post_rst_rdata", obs_rdata_a, init_val(10'd32));
    chk("post_rst_latency", 32'(lat), 32'd2);
    step();

    // Random traffic: requests held until acked, fields shuffled while waiting.
    pend_a = 0; pend_b = 0; wait_a = 0; wait_b = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend_a) begin req_a = ($urandom % 3 == 0); pend_a = req_a; wait_a = 0; end
      if (!pend_b) begin req_b = ($urandom % 3 == 0); pend_b = req_b; wait_b = 0; end
      we_a = 1'($urandom); addr_a = pick_addr(); wdata_a = $urandom;
      we_b = 1'($urandom); addr_b = pick_addr(); wdata_b = $urandom;
      if ($urandom % 150 == 0) begin
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
      if (obs_ack_a) pend_a = 0;
      else if (pend_a && ++wait_a > 60) begin chk("a_starved", 32'(wait_a), 32'd0); pend_a = 0; end
      if (obs_ack_b) pend_b = 0;
      else if (pend_b && ++wait_b > 60) begin chk("b_starved", 32'(wait_b), 32'd0); pend_b = 0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
